// File: rtl/image_op_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | image_op_pkg : shared op codes, constants and burst states.      |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
package image_op_pkg;

  typedef enum logic [1:0] {
    PIXELOP_DARK = 2'b00,
    PIXELOP_LITE = 2'b01,
    PIXELOP_INVT = 2'b10,
    PIXELOP_CKSM = 2'b11
  } pixel_op_e;

  localparam logic [7:0] PIXEL_DELTA = 8'h1f;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    ACCUM  = 2'd2
  } burst_state_e;

endpackage
`default_nettype wire

// File: rtl/image_word_op.sv
`default_nettype none
// +------------------------------------------------------------------+
// | image_word_op : combinational per-byte pixel transform.          |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
module image_word_op
  import image_op_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  operate,
  output logic [31:0] result
);

  logic [31:0] w_xf;
  logic [7:0]  w_ck;

  // Byte i of the input lands in byte (3-i) of the result.
  for (genvar gi = 0; gi < 4; gi++) begin : g_byte
    logic [7:0] w_b;
    logic [7:0] w_f;
    assign w_b = data[8*gi +: 8];
    always_comb begin
      case (operate)
        PIXELOP_DARK: w_f = w_b - PIXEL_DELTA;
        PIXELOP_LITE: w_f = w_b + PIXEL_DELTA;
        default:      w_f = 8'hff - w_b;
      endcase
    end
    assign w_xf[8*(3-gi) +: 8] = w_f;
  end

  assign w_ck   = data[7:0] ^ data[15:8] ^ data[23:16] ^ data[31:24];
  assign result = (operate == PIXELOP_CKSM) ? {24'h0, w_ck} : w_xf;

endmodule
`default_nettype wire

// File: rtl/image_burst_op.sv
`default_nettype none
// +------------------------------------------------------------------+
// | image_burst_op : handshaked burst stage applying one pixel op.   |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
module image_burst_op
  import image_op_pkg::*;
#(
  parameter int BURST_LEN = 16,
  parameter int CNT_W     = $clog2(BURST_LEN + 1)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  cfg_op,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic        err_len
);

  burst_state_e r_state, w_state_nxt;
  logic [1:0]       r_op_q;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_acc;
  logic             r_out_valid, r_out_last, r_err_len;
  logic [31:0]      r_out_data;

  logic [1:0]       w_op;
  logic [31:0]      w_res;
  logic             w_accept, w_is_ck, w_overlen, w_last;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_load, w_load_last;
  logic [31:0]      w_load_data;

  // The first word of a burst uses the live cfg_op; later words use the latched op.
  assign w_op      = (r_state == IDLE) ? cfg_op : r_op_q;
  assign w_is_ck   = (w_op == PIXELOP_CKSM);
  assign in_ready  = !r_out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_cnt_nxt = (r_state == IDLE) ? CNT_W'(1) : r_cnt + CNT_W'(1);
  assign w_overlen = !in_last && (w_cnt_nxt == CNT_W'(BURST_LEN));
  assign w_last    = in_last || w_overlen;

  image_word_op u_word_op (
    .data    (in_data),
    .operate (w_op),
    .result  (w_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_data = w_res;
    w_load_last = w_last;
    if (w_accept) begin
      if (!w_is_ck) begin
        w_load = 1'b1;
      end else if (w_last) begin
        w_load      = 1'b1;
        w_load_data = {24'h0, r_acc ^ w_res[7:0]};
        w_load_last = 1'b1;
      end
    end
    case (r_state)
      IDLE: begin
        if (w_accept && !w_last) w_state_nxt = w_is_ck ? ACCUM : STREAM;
      end
      STREAM, ACCUM: begin
        if (w_accept && w_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_q      <= 2'b00;
      r_cnt       <= '0;
      r_acc       <= 8'h00;
      r_err_len   <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= 32'h0;
      r_out_last  <= 1'b0;
    end else begin
      if (w_accept) begin
        if (r_state == IDLE) r_op_q <= cfg_op;
        r_cnt <= w_last ? '0 : w_cnt_nxt;
        if (w_is_ck) r_acc <= w_last ? 8'h00 : (r_acc ^ w_res[7:0]);
        if (w_overlen) r_err_len <= 1'b1;
      end
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_load_data;
        r_out_last  <= w_load_last;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign err_len   = r_err_len;
  assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_image_burst_op.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_image_burst_op : directed vectors for image_burst_op.         |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
module tb_image_burst_op;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  cfg_op;
  logic        in_valid, in_ready, in_last;
  logic [31:0] in_data;
  logic        out_valid, out_ready, out_last;
  logic [31:0] out_data;
  logic        busy, err_len;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  image_burst_op #(.BURST_LEN(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_op    (cfg_op),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .err_len   (err_len)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] data, input logic last);
    in_valid = 1'b1;
    in_data  = data;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cfg_op = 2'b00; in_valid = 1'b0; in_data = 32'h0;
    in_last = 1'b0; out_ready = 1'b1;
    repeat (2) tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 32'h0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_len, 0);
    chk("rst_ready", in_ready, 1);
    rst_n = 1'b1;
    tick();

    // dark, single word
    cfg_op = 2'b00;
    send(32'h01020304, 1'b1);
    chk("dark_valid", out_valid, 1);
    chk("dark_data", out_data, 32'hE5E4E3E2);
    chk("dark_last", out_last, 1);
    chk("dark_busy", busy, 0);

    // lite then invert, back to back
    cfg_op = 2'b01;
    send(32'hF0E1D2C3, 1'b1);
    chk("lite_valid", out_valid, 1);
    chk("lite_data", out_data, 32'hE2F1000F);
    cfg_op = 2'b10;
    send(32'h00FF1234, 1'b1);
    chk("inv_valid", out_valid, 1);
    chk("inv_data", out_data, 32'hCBED00FF);
    chk("inv_last", out_last, 1);
    tick();
    chk("inv_drain", out_valid, 0);

    // checksum burst; cfg_op change mid-burst must be ignored
    cfg_op = 2'b11;
    send(32'h01020304, 1'b0);
    chk("ck_v0", out_valid, 0);
    chk("ck_busy", busy, 1);
    cfg_op = 2'b00;
    send(32'h11111111, 1'b0);
    chk("ck_v1", out_valid, 0);
    send(32'hA0000000, 1'b1);
    chk("ck_valid", out_valid, 1);
    chk("ck_data", out_data, 32'h000000A4);
    chk("ck_last", out_last, 1);
    chk("ck_idle", busy, 0);
    tick();
    chk("ck_once", out_valid, 0);

    // backpressure on a 4-word dark burst
    cfg_op = 2'b00;
    send(32'h20202020, 1'b0);
    chk("bp0_data", out_data, 32'h01010101);
    chk("bp0_last", out_last, 0);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h1F1F1F1F; in_last = 1'b0;
    #1;
    chk("bp_ready0", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_v", out_valid, 1);
      chk("bp_hold_d", out_data, 32'h01010101);
      chk("bp_hold_rdy", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    chk("bp1_data", out_data, 32'h00000000);
    chk("bp1_valid", out_valid, 1);
    in_data = 32'h00000010;
    tick();
    chk("bp2_data", out_data, 32'hF1E1E1E1);
    chk("bp2_last", out_last, 0);
    in_data = 32'h44332211; in_last = 1'b1;
    tick();
    chk("bp3_data", out_data, 32'hF2031425);
    chk("bp3_last", out_last, 1);
    in_valid = 1'b0; in_last = 1'b0;
    tick();
    chk("bp_drain", out_valid, 0);

    // overlength checksum burst with BURST_LEN=4
    cfg_op = 2'b11;
    send(32'h01010101, 1'b0);
    chk("ol_v0", out_valid, 0);
    send(32'h02000000, 1'b0);
    send(32'h00300000, 1'b0);
    chk("ol_err0", err_len, 0);
    chk("ol_v2", out_valid, 0);
    send(32'h00000004, 1'b0);
    chk("ol_valid", out_valid, 1);
    chk("ol_data", out_data, 32'h00000036);
    chk("ol_last", out_last, 1);
    chk("ol_err", err_len, 1);
    chk("ol_busy", busy, 0);
    send(32'h000000FF, 1'b0);
    chk("ol_new_busy", busy, 1);
    chk("ol_new_v", out_valid, 0);
    chk("ol_sticky", err_len, 1);

    // reset in the middle of a checksum burst
    send(32'h12345678, 1'b0);
    chk("mr_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_valid", out_valid, 0);
    chk("mr_data", out_data, 32'h0);
    chk("mr_last", out_last, 0);
    chk("mr_busy0", busy, 0);
    chk("mr_err", err_len, 0);
    tick();
    rst_n = 1'b1;
    tick();
    cfg_op = 2'b11;
    send(32'h000000FF, 1'b1);
    chk("post_valid", out_valid, 1);
    chk("post_data", out_data, 32'h000000FF);
    chk("post_last", out_last, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
